// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out for a 160x120x3 framebuffer, 4x4 upscaled.
// Address is combinational from the counters; pins land two clocks later.
module vga_scanout #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter bit SYNC_NEG    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] fb_x,
    output logic [7:0] fb_y,
    input  logic [2:0] fb_dout,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS   = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_ONE  = HW'(1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SS   = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_ONE  = VW'(1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          vis0, hs0, vs0, fs0;
    logic [15:0]   h_ext, v_ext;
    logic          vis1, hs1, vs1, fs1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST)
                v_cnt <= '0;
            else
                v_cnt <= v_cnt + V_ONE;
        end else begin
            h_cnt <= h_cnt + H_ONE;
        end
    end

    assign vis0  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs0   = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign vs0   = (v_cnt >= V_SS) && (v_cnt < V_SE);
    assign fs0   = (h_cnt == '0) && (v_cnt == '0);
    assign h_ext = 16'(h_cnt) >> SCALE_SHIFT;
    assign v_ext = 16'(v_cnt) >> SCALE_SHIFT;

    // Zeroed address in blanking keeps reads inside the 160x120 array.
    assign fb_x = vis0 ? h_ext[7:0] : 8'd0;
    assign fb_y = vis0 ? v_ext[7:0] : 8'd0;

    // Stage 1 waits out the RAM read; stage 2 drives the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis1        <= 1'b0;
            hs1         <= 1'b0;
            vs1         <= 1'b0;
            fs1         <= 1'b0;
            vga_r       <= 1'b0;
            vga_g       <= 1'b0;
            vga_b       <= 1'b0;
            vga_hs      <= SYNC_NEG;
            vga_vs      <= SYNC_NEG;
            frame_start <= 1'b0;
        end else begin
            vis1        <= vis0;
            hs1         <= hs0;
            vs1         <= vs0;
            fs1         <= fs0;
            vga_r       <= vis1 & fb_dout[2];
            vga_g       <= vis1 & fb_dout[1];
            vga_b       <= vis1 & fb_dout[0];
            vga_hs      <= hs1 ^ SYNC_NEG;
            vga_vs      <= vs1 ^ SYNC_NEG;
            frame_start <= fs1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: default build with a sparse RAM, plus a shrunken
// active-high-sync build fed constant white.
module tb_vga_scanout;

    localparam int N = 13600;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] fx;
        logic [7:0] fy;
        logic [5:0] pins;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_s;
    logic [7:0] fb_x, fb_y;
    logic [2:0] fb_dout;
    logic       vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start;
    logic [7:0] sx, sy;
    logic       s_r, s_g, s_b, s_hs, s_vs, s_fs;
    logic [2:0] white = 3'b111;

    int n_chk = 0;
    int n_pass = 0;
    int cyc, cyc_s;
    bit log_en = 1'b0;
    bit mon_on = 1'b0;

    logic [7:0] lx [N];
    logic [7:0] ly [N];
    logic [5:0] lp [N];

    int mon_err = 0, mon_bad = -1;
    int fs_cnt = 0, hs_hi = 0, vs_hi = 0, col_cnt = 0;
    int ph, pv, pp;
    logic ex_vis, ex_hs, ex_vs, ex_fs;

    vec_t tv [20];

    always #5 clk = ~clk;

    vga_scanout dut (
        .clk(clk), .rst(rst), .fb_x(fb_x), .fb_y(fb_y),
        .fb_dout(fb_dout), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    vga_scanout #(
        .H_VISIBLE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VISIBLE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SCALE_SHIFT(2), .SYNC_NEG(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst_s), .fb_x(sx), .fb_y(sy),
        .fb_dout(white), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .frame_start(s_fs)
    );

    // Registered-read RAM: only pixel (5,3) holds 3'b101.
    always @(posedge clk)
        fb_dout <= (fb_x == 8'd5 && fb_y == 8'd3) ? 3'b101 : 3'b000;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0; else cyc <= cyc + 1;

    always @(posedge clk or posedge rst_s)
        if (rst_s) cyc_s <= 0; else cyc_s <= cyc_s + 1;

    always @(negedge clk)
        if (log_en && !rst && cyc < N) begin
            lx[cyc] = fb_x;
            ly[cyc] = fb_y;
            lp[cyc] = {vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start};
        end

    // Reference timing for the 56x30 build, two frames from release.
    always @(negedge clk)
        if (mon_on && !rst_s) begin
            if (cyc_s < 3360) begin
                ph = cyc_s % 56;
                pv = (cyc_s / 56) % 30;
                ex_vis = (ph < 40) && (pv < 24);
                if (sx !== (ex_vis ? 8'(ph / 4) : 8'd0) ||
                    sy !== (ex_vis ? 8'(pv / 4) : 8'd0)) begin
                    mon_err++;
                    if (mon_bad < 0) mon_bad = cyc_s;
                end
            end
            if (cyc_s >= 2 && cyc_s < 3362) begin
                pp = cyc_s - 2;
                ph = pp % 56;
                pv = (pp / 56) % 30;
                ex_vis = (ph < 40) && (pv < 24);
                ex_hs = (ph >= 44) && (ph < 52);
                ex_vs = (pv >= 26) && (pv < 28);
                ex_fs = (pp % 1680) == 0;
                if ({s_r, s_g, s_b} !== {3{ex_vis}} || s_hs !== ex_hs ||
                    s_vs !== ex_vs || s_fs !== ex_fs) begin
                    mon_err++;
                    if (mon_bad < 0) mon_bad = cyc_s;
                end
                if (s_fs) fs_cnt++;
                if (s_hs) hs_hi++;
                if (s_vs) vs_hi++;
                if (s_r | s_g | s_b) col_cnt++;
            end
        end

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    function automatic vec_t mk(int h, int v, int fx, int fy, logic [5:0] p);
        vec_t r;
        r.h = h; r.v = v; r.fx = 8'(fx); r.fy = 8'(fy); r.pins = p;
        return r;
    endfunction

    initial begin
        tv[0]  = mk(0,   0,  0,   0, 6'b000111);
        tv[1]  = mk(1,   0,  0,   0, 6'b000110);
        tv[2]  = mk(4,   1,  1,   0, 6'b000110);
        tv[3]  = mk(639, 0,  159, 0, 6'b000110);
        tv[4]  = mk(640, 0,  0,   0, 6'b000110);
        tv[5]  = mk(655, 0,  0,   0, 6'b000110);
        tv[6]  = mk(656, 0,  0,   0, 6'b000010);
        tv[7]  = mk(751, 0,  0,   0, 6'b000010);
        tv[8]  = mk(752, 0,  0,   0, 6'b000110);
        tv[9]  = mk(799, 0,  0,   0, 6'b000110);
        tv[10] = mk(639, 3,  159, 0, 6'b000110);
        tv[11] = mk(0,   4,  0,   1, 6'b000110);
        tv[12] = mk(22,  11, 5,   2, 6'b000110);
        tv[13] = mk(19,  12, 4,   3, 6'b000110);
        tv[14] = mk(20,  12, 5,   3, 6'b101110);
        tv[15] = mk(23,  12, 5,   3, 6'b101110);
        tv[16] = mk(24,  12, 6,   3, 6'b000110);
        tv[17] = mk(21,  15, 5,   3, 6'b101110);
        tv[18] = mk(656, 13, 0,   0, 6'b000010);
        tv[19] = mk(20,  16, 5,   4, 6'b000110);

        rst = 1'b1;
        rst_s = 1'b1;
        #1;
        chk("rst_fbx", int'(fb_x), 0);
        chk("rst_fby", int'(fb_y), 0);
        chk("rst_pins", int'({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start}), 6);
        chk("rst_pins_s", int'({s_r, s_g, s_b, s_hs, s_vs, s_fs}), 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_pins", int'({vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start}), 6);

        log_en = 1'b1;
        mon_on = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        rst_s = 1'b0;

        while (cyc_s < 3952) @(negedge clk);
        mon_on = 1'b0;
        chk("s_model", mon_err, 0);
        if (mon_err != 0) $display("  first bad cycle %0d", mon_bad);
        chk("s_frame_starts", fs_cnt, 2);
        chk("s_hs_high", hs_hi, 480);
        chk("s_vs_high", vs_hi, 224);
        chk("s_color_cycles", col_cnt, 1920);

        chk("mid_rgb_pre", int'({s_r, s_g, s_b}), 7);
        chk("mid_fbx_pre", int'(sx), 8);
        #2;
        rst_s = 1'b1;
        #1;
        chk("mid_rgb_async", int'({s_r, s_g, s_b}), 0);
        chk("mid_fbx_async", int'(sx), 0);
        chk("mid_fby_async", int'(sy), 0);
        chk("mid_sync_async", int'({s_hs, s_vs, s_fs}), 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_s = 1'b0;
        @(negedge clk);
        chk("rel_fs_e0", int'(s_fs), 0);
        @(negedge clk);
        chk("rel_fs_e1", int'(s_fs), 0);
        chk("rel_rgb_e1", int'({s_r, s_g, s_b}), 0);
        @(negedge clk);
        chk("rel_fs_e2", int'(s_fs), 1);
        chk("rel_rgb_e2", int'({s_r, s_g, s_b}), 7);
        @(negedge clk);
        chk("rel_fs_e3", int'(s_fs), 0);

        while (cyc < N) @(negedge clk);
        log_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            int n;
            n = tv[i].v * 800 + tv[i].h;
            n_chk++;
            if (lx[n] === tv[i].fx && ly[n] === tv[i].fy) n_pass++;
            else $display("FAIL addr(%0d,%0d): got %0d,%0d want %0d,%0d",
                          tv[i].h, tv[i].v, lx[n], ly[n], tv[i].fx, tv[i].fy);
            n_chk++;
            if (lp[n+2] === tv[i].pins) n_pass++;
            else $display("FAIL pins(%0d,%0d): got %b want %b",
                          tv[i].h, tv[i].v, lp[n+2], tv[i].pins);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
